// File: rtl/booth_mult_arbiter_if.sv
// Bundle of the requester, response and multiplier channels around booth_mult_arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface booth_mult_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_x;
    logic [N_REQ*WIDTH-1:0] req_y;

    logic                   resp_valid;
    logic                   resp_ready;
    logic [ID_W-1:0]        resp_id;
    logic [2*WIDTH-1:0]     resp_z;
    logic                   resp_err;

    logic                   mult_start;
    logic [WIDTH-1:0]       mult_x;
    logic [WIDTH-1:0]       mult_y;
    logic                   mult_valid;
    logic [2*WIDTH-1:0]     mult_z;

    modport master (
        input  req_valid, req_x, req_y, resp_ready, mult_valid, mult_z,
        output req_ready, resp_valid, resp_id, resp_z, resp_err,
               mult_start, mult_x, mult_y
    );

    modport slave (
        output req_valid, req_x, req_y, resp_ready, mult_valid, mult_z,
        input  req_ready, resp_valid, resp_id, resp_z, resp_err,
               mult_start, mult_x, mult_y
    );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one sequential Booth multiplier among N_REQ requesters.
// Define BOOTH_ARB_TIMEOUT_EN to build the WAIT-state watchdog (resp_err); otherwise resp_err is 0.
module booth_mult_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst,
    booth_mult_arbiter_if.master bus
);
    localparam int ID_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_cfg_check
        $error("booth_mult_arbiter: N_REQ must be 2..8 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    id_q;
    logic [WIDTH-1:0]   x_q;
    logic [WIDTH-1:0]   y_q;
    logic [2*WIDTH-1:0] z_q;
    logic               mult_start_q;
    logic               resp_valid_q;
    logic               mvalid_q;

    logic               grant_found_d;
    logic [ID_W-1:0]    grant_d;
    logic [N_REQ-1:0]   req_ready_d;
    logic [ID_W-1:0]    ptr_next_d;
    logic               mult_rise_d;

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;
`endif

    // Scan from ptr upward with wrap; iterating from the far end lets the nearest requester win.
    always_comb begin
        int idx;
        idx           = 0;
        grant_found_d = 1'b0;
        grant_d       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (bus.req_valid[idx]) begin
                grant_found_d = 1'b1;
                grant_d       = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready_d = '0;
        if (state_q == IDLE && grant_found_d) begin
            req_ready_d[grant_d] = 1'b1;
        end
    end

    assign ptr_next_d  = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
    assign mult_rise_d = bus.mult_valid & ~mvalid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            z_q          <= '0;
            mult_start_q <= 1'b0;
            resp_valid_q <= 1'b0;
            mvalid_q     <= 1'b0;
`ifdef BOOTH_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            mvalid_q <= bus.mult_valid;
            case (state_q)
                IDLE: begin
                    if (grant_found_d) begin
                        id_q         <= grant_d;
                        x_q          <= bus.req_x[int'(grant_d)*WIDTH +: WIDTH];
                        y_q          <= bus.req_y[int'(grant_d)*WIDTH +: WIDTH];
                        mult_start_q <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    mult_start_q <= 1'b0;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    cnt_q        <= '0;
`endif
                    state_q      <= WAIT;
                end
                // Only a fresh low-to-high transition completes; a level held over from a previous job is ignored.
                WAIT: begin
                    if (mult_rise_d) begin
                        z_q          <= bus.mult_z;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
`ifdef BOOTH_ARB_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        z_q          <= '0;
                        err_q        <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        ptr_q        <= ptr_next_d;
                        resp_valid_q <= 1'b0;
`ifdef BOOTH_ARB_TIMEOUT_EN
                        err_q        <= 1'b0;
`endif
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_d;
    assign bus.mult_start = mult_start_q;
    assign bus.mult_x     = x_q;
    assign bus.mult_y     = y_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = id_q;
    assign bus.resp_z     = z_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
    assign bus.resp_err   = err_q;
`else
    assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter: behavioural multiplier, queued requesters and a transaction-level
// reference model compared every cycle, plus directed literal checks on the response log.
module tb_booth_mult_arbiter;
    localparam int N   = 4;
    localparam int W   = 4;
    localparam int TO  = 12;
    localparam int LAT = 4;
`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    booth_mult_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    booth_mult_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Every comparison funnels through here so the summary counts stay honest.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // Behavioural multiplier: drops valid on start, raises it with the product LAT cycles later.
    logic           mv = 1'b0;
    logic [2*W-1:0] mz = '0;
    logic           multStub = 1'b0;
    int             mCnt = 0;
    int             opA = 0;
    int             opB = 0;
    assign bus.mult_valid = mv;
    assign bus.mult_z     = mz;

    always @(posedge clk) begin
        if (bus.mult_start) begin
            opA  = $signed(bus.mult_x);
            opB  = $signed(bus.mult_y);
            mCnt = LAT;
            mv  <= 1'b0;
        end else if (mCnt > 0) begin
            mCnt--;
            if (mCnt == 0 && !multStub) begin
                mv <= 1'b1;
                mz <= (2*W)'(opA * opB);
            end
        end
    end

    // Requesters: each holds valid while its queue is non-empty and pops after a handshake.
    int             qx[N][$];
    int             qy[N][$];
    logic [N-1:0]   rv = '0;
    logic [N*W-1:0] rx = '0;
    logic [N*W-1:0] ry = '0;
    assign bus.req_valid = rv;
    assign bus.req_x     = rx;
    assign bus.req_y     = ry;

    always @(posedge clk) begin
        logic [N-1:0] hs;
        hs = bus.req_valid & bus.req_ready;
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i] && qx[i].size() > 0) begin
                void'(qx[i].pop_front());
                void'(qy[i].pop_front());
            end
            rv[i] = (qx[i].size() > 0);
            if (rv[i]) begin
                rx[i*W +: W] = W'(qx[i][0]);
                ry[i*W +: W] = W'(qy[i][0]);
            end
        end
    end

    task automatic applyStimulus(input int r, input int x, input int y);
        qx[r].push_back(x);
        qy[r].push_back(y);
    endtask

    // Response log and start-pulse count for the directed checks.
    int logId[$];
    int logZ[$];
    int logErr[$];
    int startCount = 0;
    always @(posedge clk) begin
        if (rst && bus.resp_valid && bus.resp_ready) begin
            logId.push_back(int'(bus.resp_id));
            logZ.push_back($signed(bus.resp_z));
            logErr.push_back(int'(bus.resp_err));
        end
        if (bus.mult_start) startCount++;
    end

    // Reference model: one job at a time, round-robin pick, product computed arithmetically.
    typedef enum {M_IDLE, M_ISSUE, M_WAIT, M_RESP} mphase_e;
    mphase_e mPh = M_IDLE;
    int   mPtr = 0, mId = 0, mX = 0, mY = 0, mZ = 0, mErr = 0, mWait = 0;
    logic mPrevMv = 1'b0;

    function automatic int rrPick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mPh = M_IDLE; mPtr = 0; mId = 0; mX = 0; mY = 0; mZ = 0; mErr = 0; mWait = 0;
            mPrevMv = 1'b0;
        end else begin
            case (mPh)
                M_IDLE: begin
                    int g;
                    g = rrPick(bus.req_valid, mPtr);
                    if (g >= 0) begin
                        mId = g;
                        mX  = $signed(bus.req_x[g*W +: W]);
                        mY  = $signed(bus.req_y[g*W +: W]);
                        mPh = M_ISSUE;
                    end
                end
                M_ISSUE: begin
                    mWait = 0;
                    mPh   = M_WAIT;
                end
                M_WAIT: begin
                    mWait++;
                    if (bus.mult_valid && !mPrevMv) begin
                        mZ = mX * mY; mErr = 0; mPh = M_RESP;
                    end else if (TEN && mWait == TO) begin
                        mZ = 0; mErr = 1; mPh = M_RESP;
                    end
                end
                M_RESP: begin
                    if (bus.resp_ready) begin
                        mPtr = (mId + 1) % N;
                        mPh  = M_IDLE;
                    end
                end
                default: mPh = M_IDLE;
            endcase
            mPrevMv = bus.mult_valid;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            int g;
            logic [N-1:0] expReady;
            g = rrPick(bus.req_valid, mPtr);
            expReady = (mPh == M_IDLE && g >= 0) ? N'(1 << g) : '0;
            checkOutput("req_ready", 32'(bus.req_ready), 32'(expReady));
            checkOutput("mult_start", 32'(bus.mult_start), 32'(mPh == M_ISSUE));
            checkOutput("resp_valid", 32'(bus.resp_valid), 32'(mPh == M_RESP));
            if (mPh == M_ISSUE || mPh == M_WAIT) begin
                checkOutput("mult_x", 32'($signed(bus.mult_x)), mX);
                checkOutput("mult_y", 32'($signed(bus.mult_y)), mY);
            end
            if (mPh == M_RESP) begin
                checkOutput("resp_id", 32'(bus.resp_id), mId);
                checkOutput("resp_z", 32'($signed(bus.resp_z)), mZ);
                checkOutput("resp_err", 32'(bus.resp_err), mErr);
            end
        end
    end

    task automatic waitLog(input int n, input int budget);
        int c;
        c = 0;
        while (logId.size() < n && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        checkOutput("resp_count", logId.size(), n);
    endtask

    task automatic checkLog(input int k, input int id, input int z, input int err);
        if (k < logId.size()) begin
            checkOutput("log_id", logId[k], id);
            checkOutput("log_z", logZ[k], z);
            checkOutput("log_err", logErr[k], err);
        end else begin
            checkOutput("log_missing", logId.size(), k + 1);
        end
    endtask

    task automatic pulseReset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int ord[8];
        int c;
        int n;
        ord = '{0, 1, 2, 3, 0, 1, 2, 3};
        bus.resp_ready = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 0);
        checkOutput("rst_resp_valid", 32'(bus.resp_valid), 0);
        checkOutput("rst_mult_start", 32'(bus.mult_start), 0);
        checkOutput("rst_resp_err", 32'(bus.resp_err), 0);
        checkOutput("rst_mult_x", 32'(bus.mult_x), 0);
        checkOutput("rst_resp_z", 32'(bus.resp_z), 0);
        #1 rst = 1'b1;

        // Single request: 2 x 3
        applyStimulus(0, 2, 3);
        waitLog(1, 60);
        checkLog(0, 0, 6, 0);
        checkOutput("start_pulses", startCount, 1);

        // Simultaneous requesters 1 and 2 from ptr 0
        pulseReset();
        applyStimulus(1, -3, 4);
        applyStimulus(2, -2, -2);
        waitLog(3, 100);
        checkLog(1, 1, -12, 0);
        checkLog(2, 2, 4, 0);

        // Round-robin with all four requesters continuously active
        pulseReset();
        for (int i = 0; i < N; i++) begin
            applyStimulus(i, i + 1, -(i + 2));
            applyStimulus(i, i - 3, 3);
        end
        waitLog(11, 300);
        for (int k = 0; k < 8; k++) begin
            if (3 + k < logId.size()) checkOutput("rr_order", logId[3 + k], ord[k]);
        end
        checkLog(3, 0, -2, 0);
        checkLog(10, 3, 0, 0);

        // Response backpressure
        bus.resp_ready = 1'b0;
        applyStimulus(3, 7, -8);
        c = 0;
        while (!bus.resp_valid && c < 60) begin @(negedge clk); c++; end
        checkOutput("bp_resp_seen", 32'(bus.resp_valid), 1);
        applyStimulus(0, 1, 1);
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_valid", 32'(bus.resp_valid), 1);
            checkOutput("bp_id", 32'(bus.resp_id), 3);
            checkOutput("bp_z", 32'($signed(bus.resp_z)), -56);
            checkOutput("bp_no_grant", 32'(bus.req_ready), 0);
        end
        #1 bus.resp_ready = 1'b1;
        waitLog(13, 100);
        checkLog(11, 3, -56, 0);
        checkLog(12, 0, 1, 0);

        // Reset during WAIT; ptr is 1 beforehand
        applyStimulus(2, 3, 3);
        c = 0;
        while (!bus.mult_start && c < 40) begin @(negedge clk); c++; end
        checkOutput("mr_start_seen", 32'(bus.mult_start), 1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        checkOutput("mr_resp_valid", 32'(bus.resp_valid), 0);
        checkOutput("mr_mult_start", 32'(bus.mult_start), 0);
        checkOutput("mr_req_ready", 32'(bus.req_ready), 0);
        checkOutput("mr_mult_x", 32'(bus.mult_x), 0);
        checkOutput("mr_mult_y", 32'(bus.mult_y), 0);
        checkOutput("mr_resp_z", 32'(bus.resp_z), 0);
        checkOutput("mr_resp_id", 32'(bus.resp_id), 0);
        @(posedge clk); #2 rst = 1'b1;
        n = logId.size();
        repeat (10) @(posedge clk);
        #1 checkOutput("mr_no_late_resp", logId.size(), n);
        applyStimulus(0, -1, 5);
        applyStimulus(3, 2, 2);
        waitLog(15, 120);
        checkLog(13, 0, -5, 0);
        checkLog(14, 3, 4, 0);

        if (TEN) begin
            multStub = 1'b1;
            applyStimulus(1, 5, 5);
            waitLog(16, TO + 40);
            checkLog(15, 1, 0, 1);
            multStub = 1'b0;
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
